// File: rtl/rtc_bus_arbiter.sv
// Arbitrates four RTC register requesters onto a single protocol engine,
// one transaction at a time, with read-starvation promotion and WAIT timeout.
module rtc_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int STARVE_LIMIT   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       wr_req,
  input  logic       crono_req,
  input  logic       rd_req,
  input  logic [7:0] init_addr,
  input  logic [7:0] wr_addr,
  input  logic [7:0] crono_addr,
  input  logic [7:0] rd_addr,
  input  logic [7:0] init_data,
  input  logic [7:0] wr_data,
  input  logic [7:0] crono_data,
  output logic [3:0] grant,
  output logic [3:0] req_done,
  output logic       err,
  output logic       tx_start,
  output logic       tx_write,
  output logic [7:0] tx_addr,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic [7:0] tx_rdata,
  output logic [7:0] rdata,
  output logic       rdata_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [9:0] TMO_MAX    = 10'(TIMEOUT_CYCLES);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [1:0] state_r;
  logic [9:0] tmo_cnt_r;
  logic [2:0] starve_cnt_r;
  logic [3:0] grant_r;
  logic [3:0] req_done_r;
  logic       err_r;
  logic       tx_start_r;
  logic       tx_write_r;
  logic [7:0] tx_addr_r;
  logic [7:0] tx_data_r;
  logic [7:0] rdata_r;
  logic       rdata_valid_r;

  logic [3:0] win_s;
  logic [7:0] win_addr_s;
  logic [7:0] win_data_s;
  logic [9:0] tmo_nxt_s;
  logic       tmo_hit_s;

  // Winner selection: a starved read overrides the fixed init > wr > crono > rd order.
  always_comb begin
    win_s = 4'b0000;
    if (rd_req && (starve_cnt_r >= STARVE_MAX)) begin
      win_s = 4'b1000;
    end else if (init_req) begin
      win_s = 4'b0001;
    end else if (wr_req) begin
      win_s = 4'b0010;
    end else if (crono_req) begin
      win_s = 4'b0100;
    end else if (rd_req) begin
      win_s = 4'b1000;
    end else begin
      win_s = 4'b0000;
    end
  end

  // Address/data mux for the selected requester; reads carry no payload.
  always_comb begin
    win_addr_s = 8'h00;
    win_data_s = 8'h00;
    case (win_s)
      4'b0001: begin win_addr_s = init_addr;  win_data_s = init_data;  end
      4'b0010: begin win_addr_s = wr_addr;    win_data_s = wr_data;    end
      4'b0100: begin win_addr_s = crono_addr; win_data_s = crono_data; end
      4'b1000: begin win_addr_s = rd_addr;    win_data_s = 8'h00;      end
      default: begin win_addr_s = 8'h00;      win_data_s = 8'h00;      end
    endcase
  end

  assign tmo_nxt_s = tmo_cnt_r + 10'd1;
  assign tmo_hit_s = (tmo_nxt_s == TMO_MAX);

  // Transaction FSM; all outputs are registered so pulses align with ISSUE/DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      tmo_cnt_r     <= 10'd0;
      starve_cnt_r  <= 3'd0;
      grant_r       <= 4'b0000;
      req_done_r    <= 4'b0000;
      err_r         <= 1'b0;
      tx_start_r    <= 1'b0;
      tx_write_r    <= 1'b0;
      tx_addr_r     <= 8'h00;
      tx_data_r     <= 8'h00;
      rdata_r       <= 8'h00;
      rdata_valid_r <= 1'b0;
    end else begin
      tx_start_r    <= 1'b0;
      req_done_r    <= 4'b0000;
      err_r         <= 1'b0;
      rdata_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_s != 4'b0000) begin
            grant_r    <= win_s;
            tx_write_r <= ~win_s[3];
            tx_addr_r  <= win_addr_s;
            tx_data_r  <= win_data_s;
            tx_start_r <= 1'b1;
            state_r    <= ST_ISSUE;
            if (win_s[3] || !rd_req) begin
              starve_cnt_r <= 3'd0;
            end else begin
              starve_cnt_r <= starve_cnt_r + 3'd1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt_r <= 10'd0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            req_done_r <= grant_r;
            state_r    <= ST_DONE;
            if (grant_r[3]) begin
              rdata_r       <= tx_rdata;
              rdata_valid_r <= 1'b1;
            end else begin
              rdata_valid_r <= 1'b0;
            end
          end else if (tmo_hit_s) begin
            req_done_r <= grant_r;
            err_r      <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_nxt_s;
          end
        end
        ST_DONE: begin
          grant_r <= 4'b0000;
          state_r <= ST_IDLE;
        end
        default: begin
          grant_r <= 4'b0000;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign req_done    = req_done_r;
  assign err         = err_r;
  assign tx_start    = tx_start_r;
  assign tx_write    = tx_write_r;
  assign tx_addr     = tx_addr_r;
  assign tx_data     = tx_data_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;

endmodule
